// File: rtl/audio_recorder_if.sv
// Capture-side bus between the audio recorder, the CODEC read port and the
// sample RAM write port. The recorder uses the slave view; whoever drives
// start/abort and the CODEC side uses the master view.
interface audio_recorder_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 24
) ();

  // Control from the top level
  logic              start;
  logic              abort;

  // CODEC read side
  logic              read_ready;
  logic [DATA_W-1:0] readdata_left;
  logic [DATA_W-1:0] readdata_right;
  logic              read;

  // Sample RAM write side
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  // Status back to the top level
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] peak;

  modport slave (
    input  start, abort, read_ready, readdata_left, readdata_right,
    output read, mem_we, mem_addr, mem_data, busy, done, peak
  );

  modport master (
    output start, abort, read_ready, readdata_left, readdata_right,
    input  read, mem_we, mem_addr, mem_data, busy, done, peak
  );

endinterface

// File: rtl/audio_recorder.sv
// Audio recorder: drains stereo pairs from the CODEC, mixes them to mono,
// keeps one of every DECIM samples and writes a fixed-length recording of
// 2**ADDR_W samples into the sample RAM, tracking the peak magnitude.
module audio_recorder #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 24,
  parameter int DECIM  = 1
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  audio_recorder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  localparam logic [7:0]        DEC_LAST = 8'(DECIM - 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  state_t            r_state;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [7:0]        r_decCnt;
  logic              r_busy;
  logic              r_done;
  logic              r_memWe;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memData;
  logic [DATA_W-1:0] r_peak;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_mono;
  logic [DATA_W-1:0] w_abs;
  logic              w_accept;
  logic              w_lastAddr;

  // The CODEC is always drained so its FIFO never backs up; held off only
  // while reset is asserted.
  assign bus.read = bus.read_ready & ~reset;
  assign w_accept = bus.read_ready;

  // Mono mix: a one-bit-wider sum cannot overflow, and halving it always
  // fits back into DATA_W bits.
  assign w_sum  = {bus.readdata_left[DATA_W-1], bus.readdata_left}
                + {bus.readdata_right[DATA_W-1], bus.readdata_right};
  assign w_mono = w_sum[DATA_W:1];

  // Magnitude saturates at the most negative value, which has no positive
  // counterpart.
  assign w_abs = (w_mono == MOST_NEG) ? MOST_POS :
                 (w_mono[DATA_W-1] ? (~w_mono + 1'b1) : w_mono);

  assign w_lastAddr = (r_wrPtr == {ADDR_W{1'b1}});

  // Recorder FSM with all outputs registered; abort beats start everywhere
  // and suppresses any store on its edge.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wrPtr   <= '0;
      r_decCnt  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_memWe   <= 1'b0;
      r_memAddr <= '0;
      r_memData <= '0;
      r_peak    <= '0;
    end else begin
      r_memWe <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end else if (bus.start) begin
            r_state  <= CAPTURE;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_wrPtr  <= '0;
            r_decCnt <= '0;
            r_peak   <= '0;
          end
        end
        CAPTURE: begin
          if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_accept) begin
            r_decCnt <= (r_decCnt == DEC_LAST) ? 8'd0 : r_decCnt + 8'd1;
            if (r_decCnt == 8'd0) begin
              r_memWe   <= 1'b1;
              r_memAddr <= r_wrPtr;
              r_memData <= w_mono;
              if (w_abs > r_peak) begin
                r_peak <= w_abs;
              end
              if (w_lastAddr) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_wrPtr <= r_wrPtr + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_we   = r_memWe;
  assign bus.mem_addr = r_memAddr;
  assign bus.mem_data = r_memData;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.peak     = r_peak;

endmodule

// File: tb/tb_audio_recorder.sv
// Directed bench for audio_recorder: one instance with DECIM=1 covers mixing,
// restart, abort, async reset and handshake gaps; a second with DECIM=3
// covers decimation. Both use a 4-sample recording.
module tb_audio_recorder;

  logic CLOCK_50;
  logic reset;
  int   total;
  int   bad;

  audio_recorder_if #(.ADDR_W(2), .DATA_W(24)) ifA ();
  audio_recorder_if #(.ADDR_W(2), .DATA_W(24)) ifB ();

  audio_recorder #(.ADDR_W(2), .DATA_W(24), .DECIM(1)) dutA (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (ifA.slave)
  );

  audio_recorder #(.ADDR_W(2), .DATA_W(24), .DECIM(3)) dutB (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (ifB.slave)
  );

  // 100 MHz-style free-running clock
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Compare one observed value with its expected value and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic stepCycle();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drive instance A for one edge, then return just after it
  task automatic applyStimulus(input logic st, input logic ab, input logic rr,
                               input logic [23:0] l, input logic [23:0] r);
    ifA.start          = st;
    ifA.abort          = ab;
    ifA.read_ready     = rr;
    ifA.readdata_left  = l;
    ifA.readdata_right = r;
    stepCycle();
  endtask

  // Drive instance B for one edge, then return just after it
  task automatic applyStimulusB(input logic st, input logic ab, input logic rr,
                                input logic [23:0] l, input logic [23:0] r);
    ifB.start          = st;
    ifB.abort          = ab;
    ifB.read_ready     = rr;
    ifB.readdata_left  = l;
    ifB.readdata_right = r;
    stepCycle();
  endtask

  logic [23:0] mixL [4];
  logic [23:0] mixR [4];
  logic [23:0] mixE [4];

  initial begin
    total = 0;
    bad   = 0;
    mixL = '{24'd100, 24'hFFFFFD, 24'h7FFFFF, 24'h800000};
    mixR = '{24'd200, 24'd0,      24'h7FFFFF, 24'h800000};
    mixE = '{24'd150, 24'hFFFFFE, 24'h7FFFFF, 24'h800000};

    // Reset with read_ready high: read must still be held low
    reset = 1'b1;
    ifA.start = 0; ifA.abort = 0; ifA.read_ready = 1;
    ifA.readdata_left = 0; ifA.readdata_right = 0;
    ifB.start = 0; ifB.abort = 0; ifB.read_ready = 0;
    ifB.readdata_left = 0; ifB.readdata_right = 0;
    #3;
    checkOutput("rst_read", 32'(ifA.read), 32'd0);
    checkOutput("rst_busy", 32'(ifA.busy), 32'd0);
    checkOutput("rst_done", 32'(ifA.done), 32'd0);
    checkOutput("rst_we",   32'(ifA.mem_we), 32'd0);
    checkOutput("rst_addr", 32'(ifA.mem_addr), 32'd0);
    checkOutput("rst_data", 32'(ifA.mem_data), 32'd0);
    checkOutput("rst_peak", 32'(ifA.peak), 32'd0);
    ifA.read_ready = 0;
    stepCycle();
    reset = 1'b0;
    stepCycle();

    // Mono mix over a full 4-sample recording
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("mix_busy", 32'(ifA.busy), 32'd1);
    checkOutput("mix_done0", 32'(ifA.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 1, mixL[i], mixR[i]);
      checkOutput("mix_we",   32'(ifA.mem_we), 32'd1);
      checkOutput("mix_addr", 32'(ifA.mem_addr), 32'(i));
      checkOutput("mix_data", 32'(ifA.mem_data), 32'(mixE[i]));
      checkOutput("mix_done", 32'(ifA.done), (i == 3) ? 32'd1 : 32'd0);
    end
    checkOutput("mix_busy_end", 32'(ifA.busy), 32'd0);
    checkOutput("mix_peak", 32'(ifA.peak), 32'h7FFFFF);

    // Pairs accepted in DONE are discarded
    applyStimulus(0, 0, 1, 24'd5, 24'd5);
    checkOutput("done_we", 32'(ifA.mem_we), 32'd0);
    checkOutput("done_hold", 32'(ifA.done), 32'd1);

    // Restart from DONE overwrites from address 0 with peak cleared
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rs_busy", 32'(ifA.busy), 32'd1);
    checkOutput("rs_done", 32'(ifA.done), 32'd0);
    checkOutput("rs_peak", 32'(ifA.peak), 32'd0);
    applyStimulus(0, 0, 1, 24'd10, 24'd10);
    checkOutput("rs_addr", 32'(ifA.mem_addr), 32'd0);
    checkOutput("rs_data", 32'(ifA.mem_data), 32'd10);
    checkOutput("rs_peak1", 32'(ifA.peak), 32'd10);
    applyStimulus(0, 0, 1, 24'hFFFFD8, 24'hFFFFD8);
    checkOutput("rs_addr2", 32'(ifA.mem_addr), 32'd1);
    checkOutput("rs_data2", 32'(ifA.mem_data), 32'hFFFFD8);
    checkOutput("rs_peak2", 32'(ifA.peak), 32'd40);

    // Abort after two writes: write on that edge suppressed, peak held
    applyStimulus(0, 1, 1, 24'd7, 24'd7);
    checkOutput("ab_we",   32'(ifA.mem_we), 32'd0);
    checkOutput("ab_busy", 32'(ifA.busy), 32'd0);
    checkOutput("ab_done", 32'(ifA.done), 32'd0);
    checkOutput("ab_peak", 32'(ifA.peak), 32'd40);

    // Start together with abort stays in IDLE
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("sa_busy", 32'(ifA.busy), 32'd0);
    checkOutput("sa_peak", 32'(ifA.peak), 32'd40);

    // Fresh start restarts at address 0
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("fs_busy", 32'(ifA.busy), 32'd1);
    checkOutput("fs_peak", 32'(ifA.peak), 32'd0);
    applyStimulus(0, 0, 1, 24'd3, 24'd5);
    checkOutput("fs_we",   32'(ifA.mem_we), 32'd1);
    checkOutput("fs_addr", 32'(ifA.mem_addr), 32'd0);
    checkOutput("fs_data", 32'(ifA.mem_data), 32'd4);

    // Asynchronous reset mid-capture with read_ready still high
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_read", 32'(ifA.read), 32'd0);
    checkOutput("ar_we",   32'(ifA.mem_we), 32'd0);
    checkOutput("ar_busy", 32'(ifA.busy), 32'd0);
    checkOutput("ar_addr", 32'(ifA.mem_addr), 32'd0);
    checkOutput("ar_data", 32'(ifA.mem_data), 32'd0);
    checkOutput("ar_peak", 32'(ifA.peak), 32'd0);
    stepCycle();
    reset = 1'b0;
    applyStimulus(0, 0, 1, 24'd9, 24'd9);
    checkOutput("ar_idle_we",   32'(ifA.mem_we), 32'd0);
    checkOutput("ar_idle_busy", 32'(ifA.busy), 32'd0);

    // Random handshake gaps: read follows read_ready, writes stay contiguous
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int gap;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("gap_read", 32'(ifA.read), 32'd0);
        checkOutput("gap_we",   32'(ifA.mem_we), 32'd0);
      end
      applyStimulus(0, 0, 1, 24'(7 * k), 24'(3 * k));
      checkOutput("hs_read", 32'(ifA.read), 32'd1);
      checkOutput("hs_we",   32'(ifA.mem_we), 32'd1);
      checkOutput("hs_addr", 32'(ifA.mem_addr), 32'(k));
      checkOutput("hs_data", 32'(ifA.mem_data), 32'(5 * k));
    end
    checkOutput("hs_done", 32'(ifA.done), 32'd1);
    checkOutput("hs_peak", 32'(ifA.peak), 32'd15);
    applyStimulus(0, 0, 0, 0, 0);

    // Decimation by 3 on the second instance
    applyStimulusB(1, 0, 0, 0, 0);
    checkOutput("dc_busy", 32'(ifB.busy), 32'd1);
    for (int k = 0; k < 12; k++) begin
      logic expWe;
      expWe = (k % 3 == 0) && (k <= 9);
      applyStimulusB(0, 0, 1, 24'(k), 24'(k));
      checkOutput("dc_we", 32'(ifB.mem_we), 32'(expWe));
      if (expWe) begin
        checkOutput("dc_addr", 32'(ifB.mem_addr), 32'(k / 3));
        checkOutput("dc_data", 32'(ifB.mem_data), 32'(k));
      end
    end
    checkOutput("dc_done", 32'(ifB.done), 32'd1);
    checkOutput("dc_busy_end", 32'(ifB.busy), 32'd0);
    checkOutput("dc_peak", 32'(ifB.peak), 32'd9);
    applyStimulusB(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
